conv2_pixel_scheduler: RTL
==========================

// Module: conv2_pixel_scheduler
// PURPOSE
//  Streaming sequencer for the conv2 filter pipeline (18-cycle, non-stallable filter unit).
//  Issues one (filter,row,col) per cycle instead of one per ~20 cycles.
//  Retires in-order results with their coordinates through a credit-limited output FIFO.
//  The output FIFO drives a ready/valid writer into the feature-map store.
//  Sits between the layer top-level (start/done) and the filter unit plus window/weight muxes.
// PARAMETERS
//  NUM_F     32   output filters (f range 0..NUM_F-1)
//  MAP_H     14   output rows
//  MAP_W     14   output cols
//  DEPTH     32   output FIFO depth = max results in flight + buffered; must be >= 1
//  TIMEOUT   64   idle cycles with in_flight>0 and no pipe_valid before err_timeout
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high
//  start       in   1   level; begins a layer pass when sampled high in IDLE
//  busy        out  1   high in RUN or DRAIN
//  done        out  1   high in DONE and WAIT_START_LOW
//  issue_valid out  1   to filter valid_in; coordinates below are valid with it
//  issue_f     out  5   filter index -> weight/bias select
//  issue_i     out  4   output row -> window mux
//  issue_j     out  4   output col -> window mux
//  pipe_valid  in   1   filter valid_out
//  pipe_result in   32  filter result (signed, post-ReLU)
//  wr_valid    out  1   output FIFO head valid
//  wr_ready    in   1   writer accepts head
//  wr_f/i/j    out  5/4/4  head coordinates
//  wr_data     out  32  head result
//  err_unexp   out  1   sticky: pipe_valid seen with in_flight==0
//  err_timeout out  1   sticky: TIMEOUT elapsed with no pipe_valid while in_flight>0
// BEHAVIOUR
//  Reset: state=IDLE. All counters, in_flight and FIFO cleared. All outputs 0.
//   Applies mid-pass; issue_valid is low in the cycle after reset is sampled.
//  FSM:
//   IDLE->RUN on start.
//   RUN->DRAIN after the last issue (f=NUM_F-1, i=MAP_H-1, j=MAP_W-1).
//   DRAIN->DONE when in_flight==0 and FIFO is empty.
//   DONE->WAIT_START_LOW after 1 cycle.
//   WAIT_START_LOW->IDLE when start==0.
//   start is ignored outside IDLE.
//  Issue: issue_valid = (state==RUN) && (in_flight + fifo_count < DEPTH).
//   Each issue advances j; on wrap j->0, i++; on i wrap i->0, f++ (raster order, f outermost).
//   issue_* are registered counters, combinationally gated into issue_valid.
//  in_flight: +1 on issue, -1 on pipe_valid. Both in the same cycle -> unchanged.
//  Retire: on pipe_valid with in_flight>0, push {rf,ri,rj,pipe_result}, then advance the retire
//   counter in the same raster order. The filter unit is in-order, so no tag storage is needed.
//  pipe_valid with in_flight==0: set err_unexp; no push; counters unchanged.
//  FIFO: pop on wr_valid && wr_ready. Simultaneous push+pop keeps count unchanged.
//   Overflow is impossible by credit rule; push while full asserts in simulation.
//   wr_data/coords are stable while wr_valid && !wr_ready.
//  Timeout: idle counter resets on pipe_valid or when in_flight==0.
//   At TIMEOUT: set err_timeout, flush in_flight/FIFO, go to DONE.
//   Errors clear only on reset or on the next start.
//  Throughput: with wr_ready=1, issues are back-to-back.
//   Pass length = NUM_F*MAP_H*MAP_W + 18 (pipe) + 1 (FIFO) cycles, to within a few cycles.
// TESTING
//  1 Defaults, 18-cycle pipe model, wr_ready=1 -> 6272 writes, each (f,i,j) once in raster
//    order, data matches model; done high <=6300 cycles after start.
//  2 NUM_F=1 MAP_H=MAP_W=2 DEPTH=4, wr_ready=0 -> exactly 4 issues then issue_valid=0;
//    wr_ready=1 -> 4 writes (0,0,0)..(0,1,1), then done.
//  3 Random wr_ready 30% -> in_flight+fifo_count never exceeds DEPTH; no lost or duplicated writes.
//  4 reset asserted at issue 100 -> next cycle issue_valid=0, wr_valid=0;
//    new start re-issues from (0,0,0).
//  5 Pipe model drops one result -> err_timeout after 64 idle cycles, DONE, done=1;
//    spurious pipe_valid in IDLE -> err_unexp=1.
//  6 start held high through done -> stays in WAIT_START_LOW; start=0 -> IDLE, done=0;
//    start pulse during RUN has no effect.

Source files
------------

// File: rtl/conv2_pixel_scheduler.sv
// Streaming (filter,row,col) issue sequencer for the conv2 filter pipeline.
// Retires in-order results with coordinates through a credit-limited output FIFO.
module conv2_pixel_scheduler #(
    parameter int unsigned NUM_F   = 32,
    parameter int unsigned MAP_H   = 14,
    parameter int unsigned MAP_W   = 14,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        issue_valid,
    output logic [4:0]  issue_f,
    output logic [3:0]  issue_i,
    output logic [3:0]  issue_j,
    input  logic        pipe_valid,
    input  logic [31:0] pipe_result,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [4:0]  wr_f,
    output logic [3:0]  wr_i,
    output logic [3:0]  wr_j,
    output logic [31:0] wr_data,
    output logic        err_unexp,
    output logic        err_timeout
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [4:0]    f_q, f_d, rf_q, rf_d;
    logic [3:0]    i_q, i_d, ri_q, ri_d;
    logic [3:0]    j_q, j_d, rj_q, rj_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          err_unexp_q, err_unexp_d;
    logic          err_timeout_q, err_timeout_d;
    logic [44:0]   mem_q [DEPTH];
    logic [44:0]   mem_d [DEPTH];

    logic [CW:0] credit_used;
    logic        issue_en, last_issue, push, pop, fifo_full, timeout_hit;
    logic [44:0] head;

    assign credit_used = {1'b0, in_flight_q} + {1'b0, count_q};
    assign issue_en    = (state_q == S_RUN) && (credit_used < (CW+1)'(DEPTH));
    assign last_issue  = (f_q == 5'(NUM_F - 1)) && (i_q == 4'(MAP_H - 1)) && (j_q == 4'(MAP_W - 1));
    assign push        = pipe_valid && (in_flight_q != '0);
    assign pop         = wr_valid && wr_ready;
    assign fifo_full   = (count_q == CW'(DEPTH));
    assign timeout_hit = (in_flight_q != '0) && !pipe_valid && (idle_q == TW'(TIMEOUT - 1));
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        f_d           = f_q;
        i_d           = i_q;
        j_d           = j_q;
        rf_d          = rf_q;
        ri_d          = ri_q;
        rj_d          = rj_q;
        in_flight_d   = in_flight_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        idle_d        = idle_q;
        err_unexp_d   = err_unexp_q;
        err_timeout_d = err_timeout_q;
        mem_d         = mem_q;

        case (state_q)
            S_IDLE: if (start) begin
                state_d       = S_RUN;
                f_d           = '0;
                i_d           = '0;
                j_d           = '0;
                rf_d          = '0;
                ri_d          = '0;
                rj_d          = '0;
                err_unexp_d   = 1'b0;
                err_timeout_d = 1'b0;
            end
            S_RUN:   if (issue_en && last_issue) state_d = S_DRAIN;
            S_DRAIN: if (in_flight_q == '0 && count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_WAIT;
            S_WAIT:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue_en) begin
            j_d = j_q + 4'd1;
            if (j_q == 4'(MAP_W - 1)) begin
                j_d = '0;
                i_d = i_q + 4'd1;
                if (i_q == 4'(MAP_H - 1)) begin
                    i_d = '0;
                    f_d = (f_q == 5'(NUM_F - 1)) ? '0 : f_q + 5'd1;
                end
            end
        end

        // The filter unit is in-order, so the retire counter alone tags each result.
        if (push) begin
            mem_d[wr_ptr_q] = {rf_q, ri_q, rj_q, pipe_result};
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            rj_d = rj_q + 4'd1;
            if (rj_q == 4'(MAP_W - 1)) begin
                rj_d = '0;
                ri_d = ri_q + 4'd1;
                if (ri_q == 4'(MAP_H - 1)) begin
                    ri_d = '0;
                    rf_d = (rf_q == 5'(NUM_F - 1)) ? '0 : rf_q + 5'd1;
                end
            end
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

        if (issue_en && !push)      in_flight_d = in_flight_q + 1'b1;
        else if (!issue_en && push) in_flight_d = in_flight_q - 1'b1;
        if (push && !pop)           count_d = count_q + 1'b1;
        else if (!push && pop)      count_d = count_q - 1'b1;

        if (pipe_valid && in_flight_q == '0) err_unexp_d = 1'b1;

        if (pipe_valid || in_flight_q == '0 || timeout_hit) idle_d = '0;
        else                                                idle_d = idle_q + 1'b1;

        if (timeout_hit) begin
            err_timeout_d = 1'b1;
            in_flight_d   = '0;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            state_d       = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            f_q           <= '0;
            i_q           <= '0;
            j_q           <= '0;
            rf_q          <= '0;
            ri_q          <= '0;
            rj_q          <= '0;
            in_flight_q   <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            idle_q        <= '0;
            err_unexp_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_q           <= f_d;
            i_q           <= i_d;
            j_q           <= j_d;
            rf_q          <= rf_d;
            ri_q          <= ri_d;
            rj_q          <= rj_d;
            in_flight_q   <= in_flight_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            idle_q        <= idle_d;
            err_unexp_q   <= err_unexp_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE) || (state_q == S_WAIT);
    assign issue_valid = issue_en;
    assign issue_f     = f_q;
    assign issue_i     = i_q;
    assign issue_j     = j_q;
    assign wr_valid    = (count_q != '0);
    assign wr_f        = wr_valid ? head[44:40] : '0;
    assign wr_i        = wr_valid ? head[39:36] : '0;
    assign wr_j        = wr_valid ? head[35:32] : '0;
    assign wr_data     = wr_valid ? head[31:0]  : '0;
    assign err_unexp   = err_unexp_q;
    assign err_timeout = err_timeout_q;

endmodule
